// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - byte-serial instruction fetch sequencer with valid/ready output
//
// Reads one byte per enabled cycle from an asynchronous-read byte memory. It
// assembles four bytes little-endian into a 32-bit instruction, then holds that
// instruction for decode until the valid/ready handshake completes.
//
// Ports:
//   clk            - clock, rising edge
//   reset          - synchronous, active-high reset
//   fetch_en       - low freezes byte sequencing while fetching
//   mem_addr       - byte address to instruction memory (pc + byte_cnt)
//   mem_rdata      - byte read at mem_addr, same cycle
//   redirect_valid - load redirect_pc (word aligned) as new fetch PC
//   redirect_pc    - redirect target, low two bits ignored
//   instr_valid    - instr_data/instr_pc hold a complete instruction
//   instr_ready    - decode accepts the instruction
//   instr_data     - assembled instruction
//   instr_pc       - byte address of instr_data
//   busy           - high while assembling an instruction
module imem_fetch_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  busy
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_VALID = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_A = ADDR_WIDTH'(RESET_PC);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [1:0]            r_byte_cnt;
    logic [31:0]           r_instr_data;
    logic                  r_instr_valid;

    logic [ADDR_WIDTH-1:0] w_redirect_aligned;

    assign w_redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    // The adder wraps naturally at 2^ADDR_WIDTH. The PC is word aligned,
    // so byte_cnt never carries past the end of the current word.
    assign mem_addr    = r_pc + ADDR_WIDTH'(r_byte_cnt);
    assign instr_pc    = r_pc;
    assign instr_data  = r_instr_data;
    assign instr_valid = r_instr_valid;
    assign busy        = (r_state == S_FETCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC_A;
            r_byte_cnt    <= 2'd0;
            r_instr_data  <= 32'd0;
            r_instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            // The redirect wins over a same-cycle handshake. The presented
            // instruction counts as consumed, and pc+4 is never used.
            r_state       <= S_FETCH;
            r_pc          <= w_redirect_aligned;
            r_byte_cnt    <= 2'd0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (fetch_en) begin
                        r_instr_data[{r_byte_cnt, 3'b000} +: 8] <= mem_rdata;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state       <= S_VALID;
                            r_instr_valid <= 1'b1;
                        end
                    end
                end
                S_VALID: begin
                    if (instr_ready) begin
                        r_pc          <= r_pc + ADDR_WIDTH'(4);
                        r_state       <= S_FETCH;
                        r_instr_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

    localparam int AW = 5;
    localparam int MEM_BYTES = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr_data;
    logic [AW-1:0] instr_pc;
    logic          busy;

    logic [7:0] mem [MEM_BYTES];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Transaction-level model: the PC plus the number of bytes gathered so far.
    // When m_n reaches 4, the instruction is on offer.
    int m_pc = 0;
    int m_n  = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    imem_fetch_ctrl #(.ADDR_WIDTH(AW), .RESET_PC(0)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .busy           (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input int pc);
        return {mem[(pc + 3) % MEM_BYTES], mem[(pc + 2) % MEM_BYTES],
                mem[(pc + 1) % MEM_BYTES], mem[pc % MEM_BYTES]};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pc <= 0;
            m_n  <= 0;
        end else if (redirect_valid) begin
            m_pc <= int'(redirect_pc) & ~3;
            m_n  <= 0;
        end else if (m_n == 4) begin
            if (instr_ready) begin
                m_pc <= (m_pc + 4) % MEM_BYTES;
                m_n  <= 0;
            end
        end else if (fetch_en) begin
            m_n <= m_n + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_mem_addr", 32'(mem_addr), 32'((m_pc + (m_n == 4 ? 0 : m_n)) % MEM_BYTES));
            check("m_instr_pc", 32'(instr_pc), 32'(m_pc));
            check("m_instr_valid", 32'(instr_valid), 32'(m_n == 4));
            check("m_busy", 32'(busy), 32'(m_n != 4));
            if (m_n == 4)
                check("m_instr_data", instr_data, word_at(m_pc));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        byte unsigned init_bytes [MEM_BYTES] = '{
            8'h33, 8'h03, 8'h94, 8'h00,  8'hb3, 8'h03, 8'h39, 8'h41,
            8'hb3, 8'h02, 8'h5a, 8'h03,  8'h13, 8'h05, 8'h10, 8'h00,
            8'hb3, 8'h1e, 8'h9c, 8'h01,  8'h6f, 8'h00, 8'h00, 8'h00,
            8'h93, 8'h08, 8'ha0, 8'h00,  8'hb3, 8'h68, 8'hf7, 8'h00};
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = init_bytes[i];

        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; instr_ready = 1'b0;
        cyc(1);
        chk_en = 1'b1;
        cyc(1);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_data", instr_data, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // First instruction: four byte addresses, then valid.
        reset = 1'b0; fetch_en = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", 32'(mem_addr), 32'(i));
            check("seq_not_valid", 32'(instr_valid), 32'd0);
            cyc(1);
        end
        check("i0_valid", 32'(instr_valid), 32'd1);
        check("i0_data", instr_data, 32'h00940333);
        check("i0_pc", 32'(instr_pc), 32'd0);

        // Next instruction arrives five cycles later.
        cyc(5);
        check("i1_valid", 32'(instr_valid), 32'd1);
        check("i1_data", instr_data, 32'h413903b3);
        check("i1_pc", 32'(instr_pc), 32'd4);

        // Backpressure holds everything.
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_data", instr_data, 32'h413903b3);
            check("bp_pc", 32'(instr_pc), 32'd4);
            check("bp_addr", 32'(mem_addr), 32'd4);
        end
        instr_ready = 1'b1;
        cyc(1);
        check("bp_release_pc", 32'(instr_pc), 32'd8);
        check("bp_release_valid", 32'(instr_valid), 32'd0);

        // Run up to the last word, then wrap.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc(1);
            if (instr_valid && instr_pc == 5'd28) found = 1'b1;
        end
        check("wrap_reached", 32'(found), 32'd1);
        check("wrap_data", instr_data, 32'h00f768b3);
        cyc(1);
        check("wrap_pc", 32'(instr_pc), 32'd0);
        check("wrap_addr", 32'(mem_addr), 32'd0);

        // Redirect after two bytes; 0x0A aligns to 8.
        cyc(2);
        check("pre_redir_addr", 32'(mem_addr), 32'd2);
        redirect_valid = 1'b1; redirect_pc = 5'h0A;
        cyc(1);
        redirect_valid = 1'b0;
        check("redir_pc", 32'(instr_pc), 32'd8);
        check("redir_addr", 32'(mem_addr), 32'd8);
        check("redir_valid", 32'(instr_valid), 32'd0);
        cyc(4);
        check("redir_ivalid", 32'(instr_valid), 32'd1);
        check("redir_data", instr_data, 32'h035a02b3);
        check("redir_ipc", 32'(instr_pc), 32'd8);

        // Return to pc 0, then redirect during the handshake.
        instr_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 5'd0;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(4);
        check("hs_pre_valid", 32'(instr_valid), 32'd1);
        check("hs_pre_pc", 32'(instr_pc), 32'd0);
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 5'd16;
        cyc(1);
        redirect_valid = 1'b0;
        check("hs_redir_pc", 32'(instr_pc), 32'd16);
        check("hs_redir_valid", 32'(instr_valid), 32'd0);
        cyc(4);
        check("hs_valid", 32'(instr_valid), 32'd1);
        check("hs_data", instr_data, 32'h019c1eb3);
        check("hs_ipc", 32'(instr_pc), 32'd16);

        // Stall after byte 0 has been captured.
        redirect_valid = 1'b1; redirect_pc = 5'd0;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(1);
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("stall_addr", 32'(mem_addr), 32'd1);
        end
        fetch_en = 1'b1;
        cyc(3);
        check("stall_valid", 32'(instr_valid), 32'd1);
        check("stall_data", instr_data, 32'h00940333);

        // Redirect while disabled; 13 aligns to 12.
        fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 5'd13;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(2);
        check("dis_redir_addr", 32'(mem_addr), 32'd12);
        check("dis_redir_valid", 32'(instr_valid), 32'd0);
        fetch_en = 1'b1;
        cyc(2);
        check("mid_addr", 32'(mem_addr), 32'd14);

        // Reset in the middle of the fetch at pc 12.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("rst2_valid", 32'(instr_valid), 32'd0);
        check("rst2_addr", 32'(mem_addr), 32'd0);
        check("rst2_pc", 32'(instr_pc), 32'd0);
        check("rst2_data", instr_data, 32'd0);
        cyc(4);
        check("rst2_ivalid", 32'(instr_valid), 32'd1);
        check("rst2_idata", instr_data, 32'h00940333);

        cyc(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
